// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field widths, constants and result types
// used by the fp_mul result packer.
package fp_pkg;

  localparam int MAN_W = 23;
  localparam int EXP_W = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [MAN_W-1:0] QNAN_MAN = 23'h400000;

  typedef enum logic [1:0] {
    FP_NORMAL = 2'd0,
    FP_ZERO   = 2'd1,
    FP_INF    = 2'd2,
    FP_NAN    = 2'd3
  } fp_class_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/fp_mul_result_packer_if.sv
// Bus bundle for the packer: fp_mul result input, drained output stream and
// status/control. slave = the packer, master = the environment driving it.
interface fp_mul_result_packer_if #(
  parameter int DEPTH = 8
);
  import fp_pkg::*;

  // Result side has no ready: dst_valid qualifies r_* for one cycle only.
  // Output side: a word transfers on a rising edge where out_valid and
  // out_ready are both 1; out_data/out_class hold while out_valid & !out_ready.
  logic                     dst_valid;
  logic [MAN_W-1:0]         r_man;
  logic [EXP_W-1:0]         r_exp;
  logic                     r_sign;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_data;
  logic [1:0]               out_class;
  logic [$clog2(DEPTH):0]   count;
  logic                     almost_full;
  logic                     overflow;
  logic                     clr_ovf;

  modport slave (
    input  dst_valid, r_man, r_exp, r_sign, out_ready, clr_ovf,
    output out_valid, out_data, out_class, count, almost_full, overflow
  );

  modport master (
    output dst_valid, r_man, r_exp, r_sign, out_ready, clr_ovf,
    input  out_valid, out_data, out_class, count, almost_full, overflow
  );

endinterface

// File: rtl/fp_result_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count, registered
// almost-full flag and a drop indication for writes refused while full.
module fp_result_fifo #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 34,
  parameter int AF_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_req,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             full;
  logic             push;
  logic             pop;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  always_comb begin
    rd_valid  = (count != '0);
    full      = (count == CW'(DEPTH));
    pop       = rd_valid & rd_ready;
    push      = wr_req & (~full | pop);
    drop      = wr_req & full & ~pop;
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (pop && !push)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count       <= count_nxt;
      almost_full <= (count_nxt >= CW'(AF_LEVEL));
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  assign rd_data = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fp_mul_result_packer.sv
// Captures fp_mul results, canonicalises/classifies them into IEEE-754
// single words and buffers them for a valid/ready consumer.
module fp_mul_result_packer
  import fp_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AF_SLACK = 4,
  parameter int FTZ      = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  fp_mul_result_packer_if.slave  bus
);

  fp32_t       packed_res;
  fp_class_t   res_class;
  logic [33:0] rd_data;
  logic        drop;
  logic        overflow;

  // NaNs collapse to the canonical quiet NaN; subnormals optionally flush.
  always_comb begin
    packed_res = '{sign: bus.r_sign, exp: bus.r_exp, man: bus.r_man};
    res_class  = FP_NORMAL;
    if (bus.r_exp == EXP_MAX) begin
      if (bus.r_man == '0) begin
        res_class = FP_INF;
      end else begin
        res_class      = FP_NAN;
        packed_res.man = QNAN_MAN;
      end
    end else if (bus.r_exp == '0) begin
      if (bus.r_man == '0) begin
        res_class = FP_ZERO;
      end else if (FTZ != 0) begin
        res_class      = FP_ZERO;
        packed_res.man = '0;
      end
    end
  end

  fp_result_fifo #(
    .DEPTH    (DEPTH),
    .WIDTH    (34),
    .AF_LEVEL (DEPTH - AF_SLACK)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .wr_req      (bus.dst_valid),
    .wr_data     ({res_class, packed_res}),
    .rd_ready    (bus.out_ready),
    .rd_valid    (bus.out_valid),
    .rd_data     (rd_data),
    .count       (bus.count),
    .almost_full (bus.almost_full),
    .drop        (drop)
  );

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (bus.clr_ovf)
      overflow <= 1'b0;
  end

  assign bus.out_data  = rd_data[31:0];
  assign bus.out_class = rd_data[33:32];
  assign bus.overflow  = overflow;

endmodule

// File: doc/fp_mul_result_packer.md
Name: fp_mul_result_packer

Overview:
Receiving end of the fp_mul result interface. Each cycle fp_mul may present one result on r_man/r_exp/r_sign with dst_valid. The packer captures it with no backpressure toward fp_mul, packs it into an IEEE-754 single-precision word and classifies it. Results are buffered in a FIFO and drained over a valid/ready stream. almost_full lets the operand issuer throttle src_valid before the buffer can overflow.

Parameters:
DEPTH, 8, FIFO entries; power of 2, >= 4
AF_SLACK, 4, almost_full asserts when count >= DEPTH - AF_SLACK; must be >= fp_mul latency + 1
FTZ, 1, 1 = subnormal results flushed to signed zero; 0 = passed through with class NORMAL

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
dst_valid  in  1  fp_mul result valid, single-cycle qualifier, no ready
r_man  in  23  result mantissa (fraction, hidden bit excluded)
r_exp  in  8  result biased exponent
r_sign  in  1  result sign
out_valid  out  1  buffered result available
out_ready  in  1  consumer accepts out_data this cycle
out_data  out  32  {sign, exp[7:0], man[22:0]}
out_class  out  2  0 NORMAL, 1 ZERO, 2 INF, 3 NAN
count  out  log2(DEPTH)+1  current occupancy
almost_full  out  1  throttle hint to issuer
overflow  out  1  sticky: a result was dropped
clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (rstn low, async): rd/wr pointers 0, count 0, out_valid 0, out_data 0, out_class 0, almost_full 0, overflow 0. FIFO storage is not reset.
- Classification happens combinationally at the input, before the write:
  - exp==255, man==0 -> INF.
  - exp==255, man!=0 -> NAN; stored man is forced to 23'h400000 (canonical quiet NaN). Sign is preserved.
  - exp==0, man==0 -> ZERO.
  - exp==0, man!=0: FTZ=1 -> stored as {sign,0,0}, class ZERO. FTZ=0 -> stored unchanged, class NORMAL.
  - All other inputs -> NORMAL.
- Push = dst_valid & (!full | pop). Pop = out_valid & out_ready.
- Full and push without pop: the result is dropped, pointers are unchanged, and overflow is set on the next edge.
- Full with simultaneous dst_valid and pop: both happen; count stays DEPTH; no overflow.
- Empty with simultaneous dst_valid: no bypass. The entry appears on the next cycle.
- Latency: dst_valid sampled at edge N gives out_valid=1 with that data after edge N (cycle N+1). Minimum latency 1 cycle.
- Output is first-word-fall-through:
  - out_data/out_class = entry at rd_ptr when out_valid=1.
  - out_data/out_class are forced to 0 when empty.
  - out_valid = (count != 0).
  - Data is held stable while out_valid & !out_ready.
- Pointers are log2(DEPTH) bits and wrap naturally. count is a separate register, updated +1 on push only, -1 on pop only, unchanged on both or neither.
- almost_full is registered and derived from the next value of count, so it is coincident with count.
- overflow stays set until clr_ovf. clr_ovf and a new drop in the same cycle -> overflow remains 1 (set wins).
- Reset mid-stream discards all entries. A dst_valid during reset is ignored.

Decomposition:
- Package fp_pkg:
  - MAN_W=23, EXP_W=8, EXP_MAX=8'hFF, QNAN_MAN=23'h400000.
  - fp_class_t enum {FP_NORMAL, FP_ZERO, FP_INF, FP_NAN}.
  - Packed struct fp32_t {sign, exp, man}.
- One sub-module: fp_result_fifo.
  - Generic DEPTH x WIDTH FWFT FIFO: count, full, empty, almost_full threshold.
  - Instantiated with WIDTH=34 (32 data + 2 class).
- Classification and packing stay in the top.

Test Plan:
- Reset then single result r_sign=0, r_exp=8'h7F, r_man=0 -> next cycle out_valid=1, out_data=32'h3F800000, class 0, count=1. Pop empties it.
- Four back-to-back inputs (exp=255/man=0 sign 1; exp=255/man=5; exp=0/man=0; exp=0/man=1, FTZ=1) -> out_data FF800000/class 2, 7FC00000/class 3, 00000000/class 1, 00000000/class 1, drained in order.
- out_ready=0, 9 consecutive dst_valid with DEPTH=8 -> almost_full rises when count=4, count saturates at 8, 9th dropped, overflow=1. Drain yields exactly the first 8 in order.
- FIFO full, dst_valid with out_ready=1 in the same cycle -> count stays 8, overflow stays 0, the new word is last out.
- overflow=1, assert clr_ovf -> overflow=0 next cycle. clr_ovf together with a drop -> overflow stays 1.
- 3 entries buffered, pulse rstn low asynchronously between edges -> out_valid, count and almost_full go to 0 immediately. Entries are not replayed after release.
